rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
Sits directly downstream of the reset-button debouncer. It consumes that block's stretched, active-high reset-request pulse and releases the weather-box subsystems in a fixed order: core logic, then the sensor bus, then peripherals (display/logger). Sensor release is gated on a sensor-ready handshake with a timeout. A fault flag is raised if the sensor never reports ready.

Parameters:
HOLD_CYCLES, 1024, cycles all resets stay asserted after i_rst_req is first sampled low; must be >= 1.
STAGE_GAP, 256, cycles between successive stage releases; must be >= 1.
SENSOR_TIMEOUT, 65535, max cycles to wait for synced i_sensor_ready after sensor release; must be >= 1.
CNT_W, 16, counter width; must hold max(HOLD_CYCLES, STAGE_GAP, SENSOR_TIMEOUT).

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, ACTIVE HIGH
i_rst_req  input  1  debounced reset request, same clock domain, level-sensitive, high = hold system in reset
i_sensor_ready  input  1  sensor power-good/ready, asynchronous, high = ready
o_rst_core  output  1  core reset, active high
o_rst_sensor  output  1  sensor-bus reset, active high
o_rst_periph  output  1  peripheral reset, active high
o_ready  output  1  sequence complete
o_fault  output  1  sensor timeout occurred

Behaviour:
- Reset values (i_rst high, asynchronous): o_rst_core=o_rst_sensor=o_rst_periph=1, o_ready=0, o_fault=0, state=HOLD, counter=HOLD_CYCLES-1, synchronizer flops=0.
- i_sensor_ready passes through a 2-flop synchronizer (sens_s). It adds 2 cycles of latency and is never used unsynchronized.
- All outputs are registered; no combinational paths from inputs to outputs.
- FSM states:
  - HOLD: all resets are 1. If i_rst_req=1, reload the counter to HOLD_CYCLES-1. Otherwise decrement the counter. When counter==0 and i_rst_req=0, go to REL_CORE and drive o_rst_core to 0 on that edge. Result: o_rst_core falls on the HOLD_CYCLES-th edge at which i_rst_req is sampled 0 consecutively.
  - REL_CORE: counter counts STAGE_GAP-1 down to 0. At 0, drive o_rst_sensor to 0, load SENSOR_TIMEOUT-1, and go to WAIT_SENS.
  - WAIT_SENS: if sens_s=1, load STAGE_GAP-1 and go to REL_PERIPH. Otherwise, if counter==0, go to FAULT. Otherwise decrement.
  - REL_PERIPH: count STAGE_GAP-1 down to 0. At 0, drive o_rst_periph to 0 and o_ready to 1 on the same edge, and go to RUN.
  - RUN: steady state. sens_s is ignored.
  - FAULT: o_fault=1, o_rst_sensor re-asserted to 1, o_rst_periph=1, o_rst_core stays 0, o_ready=0. The block stays here until i_rst_req or i_rst.
- i_rst_req=1 in any state other than HOLD: on the next edge, all three resets go to 1, o_ready=0, o_fault=0, counter reloads to HOLD_CYCLES-1, and state goes to HOLD. This has priority over every other transition in that cycle, including a simultaneous sens_s rise or counter==0.
- The sensor check is a level check, so sens_s already high on entry to WAIT_SENS advances on the first WAIT_SENS cycle.
- The counter decrements saturate at 0; there is no wrap-around.
- Release order is invariant: core, then sensor, then periph. A reset is never released before the preceding stage.
- i_rst asserted mid-sequence: immediate asynchronous return to reset values. After deassertion, the sequence restarts from HOLD.

Decomposition:
- Shared package rst_seq_pkg:
  - state enum constants HOLD, REL_CORE, WAIT_SENS, REL_PERIPH, RUN, FAULT (3-bit);
  - localparam defaults for HOLD_CYCLES, STAGE_GAP and SENSOR_TIMEOUT used by top-level instantiation.
- One sub-module: sync_2ff, a 2-flop synchronizer with async active-high reset to 0. It is reusable for other async board inputs.

Test Plan:
All scenarios use HOLD_CYCLES=8, STAGE_GAP=4, SENSOR_TIMEOUT=16, CNT_W=5.
1. Deassert i_rst with i_rst_req=0 and i_sensor_ready=1 → o_rst_core falls 8 cycles after reset release; o_rst_sensor falls 4 cycles later; o_rst_periph falls and o_ready rises 4 cycles after WAIT_SENS exit.
2. Pulse i_rst_req high for 3 cycles while in RUN → next edge: all resets 1, o_ready 0; o_rst_core falls 8 cycles after i_rst_req returns low.
3. Hold i_sensor_ready=0 → 16 cycles after o_rst_sensor falls, o_fault=1, o_rst_sensor=1, o_rst_periph=1, o_ready=0. A subsequent i_rst_req pulse clears o_fault and the sequence reruns.
4. Raise i_sensor_ready 5 cycles after o_rst_sensor falls → WAIT_SENS exits after the 2-cycle sync delay; no fault; o_ready rises 4 cycles after exit.
5. Toggle i_rst_req high for 1 cycle during HOLD at counter=2 → counter reloads; o_rst_core falls only after 8 further consecutive low samples.
6. Assert i_rst asynchronously mid-REL_PERIPH → all outputs return to reset values without waiting for a clock edge; after release the full sequence repeats identically to scenario 1.

Source files
------------

// File: rtl/rst_sequencer_pkg.sv
// Shared types and default timing for the reset sequencer.
// Provides the FSM state encoding and default cycle counts.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    REL_CORE   = 3'd1,
    WAIT_SENS  = 3'd2,
    REL_PERIPH = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_t;

  localparam int HOLD_CYCLES_DEF    = 1024;
  localparam int STAGE_GAP_DEF      = 256;
  localparam int SENSOR_TIMEOUT_DEF = 65535;
  localparam int CNT_W_DEF          = 16;

endpackage

// File: rtl/rst_sequencer_if.sv
// Request/ready inputs and staged reset outputs of the sequencer.
// slave: sequencer side; master: board/testbench side.
interface rst_sequencer_if;

  logic i_rst_req;
  logic i_sensor_ready;
  logic o_rst_core;
  logic o_rst_sensor;
  logic o_rst_periph;
  logic o_ready;
  logic o_fault;

  modport slave (
    input  i_rst_req,
    input  i_sensor_ready,
    output o_rst_core,
    output o_rst_sensor,
    output o_rst_periph,
    output o_ready,
    output o_fault
  );

  modport master (
    output i_rst_req,
    output i_sensor_ready,
    input  o_rst_core,
    input  o_rst_sensor,
    input  o_rst_periph,
    input  o_ready,
    input  o_fault
  );

endinterface

// File: rtl/rst_sequencer_sync.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports: i_clk, i_rst (async, high), i_d (async in), o_q (synced).
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rst_sequencer.sv
// Releases core, sensor bus, then peripherals after a reset request.
// Ports: i_clk, i_rst (async, high), bus (request/ready in, resets/status out).
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP      = STAGE_GAP_DEF,
  parameter int SENSOR_TIMEOUT = SENSOR_TIMEOUT_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input logic             i_clk,
  input logic             i_rst,
  rst_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(SENSOR_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_sens_s;

  logic r_rst_core;
  logic r_rst_sensor;
  logic r_rst_periph;
  logic r_ready;
  logic r_fault;

  logic w_rst_core_d;
  logic w_rst_sensor_d;
  logic w_rst_periph_d;
  logic w_ready_d;
  logic w_fault_d;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_sensor_ready),
    .o_q   (w_sens_s)
  );

  assign w_cnt_zero = (r_cnt == '0);
  // Saturating decrement: never wraps below zero.
  assign w_cnt_dec  = w_cnt_zero ? '0 : r_cnt - 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= HOLD;
      r_cnt        <= HOLD_LD;
      r_rst_core   <= 1'b1;
      r_rst_sensor <= 1'b1;
      r_rst_periph <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_rst_core   <= w_rst_core_d;
      r_rst_sensor <= w_rst_sensor_d;
      r_rst_periph <= w_rst_periph_d;
      r_ready      <= w_ready_d;
      r_fault      <= w_fault_d;
    end
  end

  // A request outranks every other transition, in any state.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = w_cnt_dec;
    if (bus.i_rst_req) begin
      w_nxt_state = HOLD;
      w_nxt_cnt   = HOLD_LD;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_cnt_zero) begin
            w_nxt_state = REL_CORE;
            w_nxt_cnt   = GAP_LD;
          end
        end
        REL_CORE: begin
          if (w_cnt_zero) begin
            w_nxt_state = WAIT_SENS;
            w_nxt_cnt   = TO_LD;
          end
        end
        WAIT_SENS: begin
          if (w_sens_s) begin
            w_nxt_state = REL_PERIPH;
            w_nxt_cnt   = GAP_LD;
          end else if (w_cnt_zero) begin
            w_nxt_state = FAULT;
          end
        end
        REL_PERIPH: begin
          if (w_cnt_zero) begin
            w_nxt_state = RUN;
          end
        end
        RUN, FAULT: begin
          w_nxt_cnt = r_cnt;
        end
        default: begin
          w_nxt_state = HOLD;
          w_nxt_cnt   = HOLD_LD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  always_comb begin
    w_rst_core_d   = 1'b1;
    w_rst_sensor_d = 1'b1;
    w_rst_periph_d = 1'b1;
    w_ready_d      = 1'b0;
    w_fault_d      = 1'b0;
    unique case (1'b1)
      (w_nxt_state == REL_CORE): begin
        w_rst_core_d = 1'b0;
      end
      (w_nxt_state == WAIT_SENS),
      (w_nxt_state == REL_PERIPH): begin
        w_rst_core_d   = 1'b0;
        w_rst_sensor_d = 1'b0;
      end
      (w_nxt_state == RUN): begin
        w_rst_core_d   = 1'b0;
        w_rst_sensor_d = 1'b0;
        w_rst_periph_d = 1'b0;
        w_ready_d      = 1'b1;
      end
      (w_nxt_state == FAULT): begin
        w_rst_core_d = 1'b0;
        w_fault_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_rst_core   = r_rst_core;
  assign bus.o_rst_sensor = r_rst_sensor;
  assign bus.o_rst_periph = r_rst_periph;
  assign bus.o_ready      = r_ready;
  assign bus.o_fault      = r_fault;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer with short timing parameters.
// Expected output changes are queued with their cycle; a monitor checks them.
module tb_rst_sequencer;

  typedef struct {
    logic [4:0] v;
    int         cyc;
  } exp_t;

  // Output vector order: {core, sensor, periph, ready, fault}
  localparam logic [4:0] V_RST   = 5'b11100;
  localparam logic [4:0] V_CORE  = 5'b01100;
  localparam logic [4:0] V_SENS  = 5'b00100;
  localparam logic [4:0] V_RUN   = 5'b00010;
  localparam logic [4:0] V_FAULT = 5'b01101;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   mon_en;
  logic [4:0] prev;
  exp_t sb_q[$];

  rst_sequencer_if bus();

  rst_sequencer #(
    .HOLD_CYCLES    (8),
    .STAGE_GAP      (4),
    .SENSOR_TIMEOUT (16),
    .CNT_W          (5)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] outs();
    return {bus.o_rst_core, bus.o_rst_sensor,
            bus.o_rst_periph, bus.o_ready, bus.o_fault};
  endfunction

  always @(negedge clk) begin
    logic [4:0] now;
    exp_t e;
    now = outs();
    if (mon_en && now !== prev) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change: got %b at cyc %0d, required no change",
                 now, cyc);
      end else begin
        e = sb_q.pop_front();
        if (now !== e.v || cyc != e.cyc) begin
          n_err++;
          $display("FAIL seq_event: got %b at cyc %0d, required %b at cyc %0d",
                   now, cyc, e.v, e.cyc);
        end
      end
      prev = now;
    end
  end

  task automatic push(input logic [4:0] v, input int c);
    exp_t e;
    e.v   = v;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [4:0] got,
                     input logic [4:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", nm, got, req);
    end
  endtask

  task automatic seq_from_release(input int e0);
    push(V_CORE, e0 + 8);
    push(V_SENS, e0 + 12);
    push(V_RUN,  e0 + 17);
  endtask

  initial begin
    int t;
    n_vec  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    prev   = V_RST;
    rst    = 1'b0;
    bus.i_rst_req      = 1'b0;
    bus.i_sensor_ready = 1'b1;
    #2 rst = 1'b1;
    #1 chk("reset_values", outs(), V_RST);
    mon_en = 1'b1;
    wait_to(3);

    // 1: power-up sequence, sensor already ready
    rst = 1'b0;
    t = cyc;
    seq_from_release(t);
    wait_to(t + 20);

    // 2: three-cycle request pulse from RUN
    t = cyc;
    bus.i_rst_req = 1'b1;
    push(V_RST,  t + 1);
    push(V_CORE, t + 11);
    push(V_SENS, t + 15);
    push(V_RUN,  t + 20);
    wait_to(t + 3);
    bus.i_rst_req = 1'b0;
    wait_to(t + 23);

    // 3: sensor never ready -> fault, then request clears it
    t = cyc;
    bus.i_sensor_ready = 1'b0;
    bus.i_rst_req = 1'b1;
    push(V_RST,   t + 1);
    push(V_CORE,  t + 9);
    push(V_SENS,  t + 13);
    push(V_FAULT, t + 29);
    wait_to(t + 1);
    bus.i_rst_req = 1'b0;
    wait_to(t + 32);
    chk("fault_hold", outs(), V_FAULT);
    t = cyc;
    bus.i_sensor_ready = 1'b1;
    bus.i_rst_req = 1'b1;
    push(V_RST,  t + 1);
    push(V_CORE, t + 9);
    push(V_SENS, t + 13);
    push(V_RUN,  t + 18);
    wait_to(t + 1);
    bus.i_rst_req = 1'b0;
    wait_to(t + 21);

    // 4: sensor ready arrives 5 cycles into WAIT_SENS
    t = cyc;
    bus.i_sensor_ready = 1'b0;
    bus.i_rst_req = 1'b1;
    push(V_RST,  t + 1);
    push(V_CORE, t + 9);
    push(V_SENS, t + 13);
    push(V_RUN,  t + 25);
    wait_to(t + 1);
    bus.i_rst_req = 1'b0;
    wait_to(t + 18);
    bus.i_sensor_ready = 1'b1;
    wait_to(t + 28);

    // 5: one-cycle request in HOLD at counter 2 reloads the hold
    t = cyc;
    bus.i_rst_req = 1'b1;
    push(V_RST,  t + 1);
    push(V_CORE, t + 15);
    push(V_SENS, t + 19);
    push(V_RUN,  t + 24);
    wait_to(t + 1);
    bus.i_rst_req = 1'b0;
    wait_to(t + 6);
    bus.i_rst_req = 1'b1;
    wait_to(t + 7);
    bus.i_rst_req = 1'b0;
    wait_to(t + 27);

    // 6: async reset in REL_PERIPH, then full repeat
    t = cyc;
    bus.i_rst_req = 1'b1;
    push(V_RST,  t + 1);
    push(V_CORE, t + 9);
    push(V_SENS, t + 13);
    wait_to(t + 1);
    bus.i_rst_req = 1'b0;
    wait_to(t + 15);
    chk("in_rel_periph", outs(), V_SENS);
    #2 rst = 1'b1;
    push(V_RST, t + 15);
    #1 chk("async_reset", outs(), V_RST);
    wait_to(t + 17);
    rst = 1'b0;
    t = cyc;
    seq_from_release(t);
    wait_to(t + 20);
    chk("final_run", outs(), V_RUN);

    wait_to(cyc + 2);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending events, required 0",
               sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
